// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Hits complete in one cycle; misses write back a dirty victim, then refill one word per cycle.
module data_cache #(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_valid,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_hit,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS   = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_REFILL,
    S_COMPLETE
  } state_t;

  state_t state, state_next;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][4];

  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [1:0]  k_q;

  logic [INDEX_BITS-1:0] cpu_index, req_index;
  logic [TAG_BITS-1:0]   cpu_tag, req_tag;
  logic [1:0]            cpu_off, req_off;
  logic                  lookup_hit, accept, victim_dirty;
  logic                  unused_addr_lsb;

  assign cpu_index = cpu_addr[4 +: INDEX_BITS];
  assign cpu_tag   = cpu_addr[31 -: TAG_BITS];
  assign cpu_off   = cpu_addr[3:2];
  assign req_index = req_addr[4 +: INDEX_BITS];
  assign req_tag   = req_addr[31 -: TAG_BITS];
  assign req_off   = req_addr[3:2];
  assign unused_addr_lsb = ^{cpu_addr[1:0], req_addr[1:0]};

  assign cpu_ready    = (state == S_IDLE);
  assign accept       = cpu_ready && cpu_req_valid;
  assign lookup_hit   = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
  assign victim_dirty = valid_q[cpu_index] && dirty_q[cpu_index];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory port is purely a function of state so a reset mid-miss drops it at once.
  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    case (state)
      S_IDLE: begin
        if (accept && !lookup_hit) begin
          state_next = victim_dirty ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {tag_q[req_index], req_index, k_q, 2'b00};
        mem_din   = data_q[req_index][k_q];
        if (k_q == 2'd3) state_next = S_REFILL;
      end
      S_REFILL: begin
        mem_read = 1'b1;
        mem_addr = {req_tag, req_index, k_q, 2'b00};
        if (k_q == 2'd3) state_next = S_COMPLETE;
      end
      S_COMPLETE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q        <= '0;
      dirty_q        <= '0;
      req_addr       <= '0;
      req_write      <= 1'b0;
      req_wdata      <= '0;
      k_q            <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_hit        <= 1'b0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          k_q <= '0;
          if (accept) begin
            if (lookup_hit) begin
              cpu_resp_valid <= 1'b1;
              cpu_hit        <= 1'b1;
              cpu_rdata      <= cpu_write ? '0 : data_q[cpu_index][cpu_off];
              hit_count      <= hit_count + 32'd1;
              if (cpu_write) dirty_q[cpu_index] <= 1'b1;
            end else begin
              req_addr  <= cpu_addr;
              req_write <= cpu_write;
              req_wdata <= cpu_wdata;
            end
          end
        end
        S_WRITEBACK: begin
          k_q <= k_q + 2'd1;
        end
        S_REFILL: begin
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            valid_q[req_index] <= 1'b1;
            dirty_q[req_index] <= 1'b0;
          end
        end
        S_COMPLETE: begin
          cpu_resp_valid <= 1'b1;
          cpu_hit        <= 1'b0;
          cpu_rdata      <= req_write ? '0 : data_q[req_index][req_off];
          miss_count     <= miss_count + 32'd1;
          if (req_write) dirty_q[req_index] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone decide residency.
  always_ff @(posedge clk) begin
    if (accept && lookup_hit && cpu_write) begin
      data_q[cpu_index][cpu_off] <= cpu_wdata;
    end
    if (state == S_REFILL) begin
      data_q[req_index][k_q] <= mem_dout;
      if (k_q == 2'd3) tag_q[req_index] <= req_tag;
    end
    if (state == S_COMPLETE && req_write) begin
      data_q[req_index][req_off] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a word-addressed memory model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid;
  logic [31:0] cpu_addr;
  logic        cpu_write;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_addr [8];
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  int n_rd, n_wr;

  always #5 clk = ~clk;

  data_cache #(.NUM_LINES(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  assign mem_dout = (mem_addr[31:12] == 20'd0 && mem_addr[1:0] == 2'd0) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[11:2]] <= mem_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and expects the response exactly lat cycles after acceptance.
  task automatic access(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input int lat,
                        input logic [31:0] exp_rd, input logic exp_hit);
    cpu_req_valid = 1'b1;
    cpu_addr      = addr;
    cpu_write     = wr;
    cpu_wdata     = wd;
    n_rd = 0;
    n_wr = 0;
    check({tag, "_ready"}, {31'd0, cpu_ready}, 32'd1);
    for (int c = 1; c <= lat; c++) begin
      step();
      if (c == 1) cpu_req_valid = 1'b0;
      if (c < lat) begin
        if (cpu_resp_valid !== 1'b0) check({tag, "_early_resp"}, {31'd0, cpu_resp_valid}, 32'd0);
        if (mem_read && mem_write) check({tag, "_rd_wr_both"}, 32'd1, 32'd0);
        if (mem_read && n_rd < 8) begin rd_addr[n_rd] = mem_addr; n_rd++; end
        if (mem_write && n_wr < 8) begin wr_addr[n_wr] = mem_addr; wr_data[n_wr] = mem_din; n_wr++; end
      end
    end
    check({tag, "_resp_valid"}, {31'd0, cpu_resp_valid}, 32'd1);
    check({tag, "_rdata"}, cpu_rdata, exp_rd);
    check({tag, "_hit"}, {31'd0, cpu_hit}, {31'd0, exp_hit});
    check({tag, "_ready_after"}, {31'd0, cpu_ready}, 32'd1);
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[32'h40] = 32'hDEADBEEF;
    reset = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_addr = '0;
    cpu_write = 1'b0;
    cpu_wdata = '0;
    step();
    check("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_hit", {31'd0, cpu_hit}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_ready", {31'd0, cpu_ready}, 32'd1);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    reset = 1'b1;
    step();

    access("ld100", 32'h100, 1'b0, 32'h0, 6, 32'hDEADBEEF, 1'b0);
    check("ld100_nrd", n_rd, 32'd4);
    check("ld100_nwr", n_wr, 32'd0);
    for (int i = 0; i < 4; i++) check("ld100_rdaddr", rd_addr[i], 32'h100 + 32'(4 * i));
    check("ld100_misses", miss_count, 32'd1);

    access("ld104", 32'h104, 1'b0, 32'h0, 1, 32'h1000_0041, 1'b1);
    check("ld104_nrd", n_rd, 32'd0);
    check("ld104_hits", hit_count, 32'd1);

    access("st100", 32'h100, 1'b1, 32'h12345678, 1, 32'h0, 1'b1);
    check("st100_hits", hit_count, 32'd2);

    access("ld500", 32'h500, 1'b0, 32'h0, 10, 32'h1000_0140, 1'b0);
    check("ld500_nwr", n_wr, 32'd4);
    check("ld500_nrd", n_rd, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("ld500_wraddr", wr_addr[i], 32'h100 + 32'(4 * i));
      check("ld500_rdaddr", rd_addr[i], 32'h500 + 32'(4 * i));
    end
    check("ld500_wd0", wr_data[0], 32'h12345678);
    check("ld500_wd1", wr_data[1], 32'h1000_0041);
    check("ld500_wd3", wr_data[3], 32'h1000_0043);
    check("ld500_mem40", mem[32'h40], 32'h12345678);
    check("ld500_misses", miss_count, 32'd2);

    access("st204", 32'h204, 1'b1, 32'hCAFE, 6, 32'h0, 1'b0);
    check("st204_nwr", n_wr, 32'd0);
    access("ld204", 32'h204, 1'b0, 32'h0, 1, 32'hCAFE, 1'b1);
    check("ld204_mem81", mem[32'h81], 32'h1000_0081);
    check("ld204_misses", miss_count, 32'd3);
    check("ld204_hits", hit_count, 32'd3);

    b2b_addr[0] = 32'h200; b2b_data[0] = 32'h1000_0080;
    b2b_addr[1] = 32'h204; b2b_data[1] = 32'hCAFE;
    b2b_addr[2] = 32'h208; b2b_data[2] = 32'h1000_0082;
    b2b_addr[3] = 32'h20C; b2b_data[3] = 32'h1000_0083;
    cpu_req_valid = 1'b1;
    cpu_write = 1'b0;
    cpu_addr = b2b_addr[0];
    for (int i = 0; i < 4; i++) begin
      step();
      check("b2b_resp_valid", {31'd0, cpu_resp_valid}, 32'd1);
      check("b2b_rdata", cpu_rdata, b2b_data[i]);
      check("b2b_hit", {31'd0, cpu_hit}, 32'd1);
      if (i < 3) cpu_addr = b2b_addr[i + 1];
      else cpu_req_valid = 1'b0;
    end
    step();
    check("b2b_resp_drop", {31'd0, cpu_resp_valid}, 32'd0);
    check("b2b_hits", hit_count, 32'd7);

    cpu_req_valid = 1'b1;
    cpu_addr = 32'h600;
    cpu_write = 1'b0;
    step();
    cpu_req_valid = 1'b0;
    check("wb_k0_write", {31'd0, mem_write}, 32'd1);
    check("wb_k0_addr", mem_addr, 32'h200);
    step();
    check("wb_k1_write", {31'd0, mem_write}, 32'd1);
    check("wb_k1_addr", mem_addr, 32'h204);
    check("wb_k1_din", mem_din, 32'hCAFE);
    reset = 1'b0;
    #1;
    check("abort_mem_write", {31'd0, mem_write}, 32'd0);
    check("abort_mem_read", {31'd0, mem_read}, 32'd0);
    check("abort_ready", {31'd0, cpu_ready}, 32'd1);
    check("abort_resp", {31'd0, cpu_resp_valid}, 32'd0);
    check("abort_misses", miss_count, 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cpu_resp_valid !== 1'b0 || mem_write !== 1'b0) check("abort_quiet", {30'd0, cpu_resp_valid, mem_write}, 32'd0);
    end
    check("abort_mem81", mem[32'h81], 32'h1000_0081);

    access("ld600", 32'h600, 1'b0, 32'h0, 6, 32'h1000_0180, 1'b0);
    check("ld600_nwr", n_wr, 32'd0);
    check("ld600_misses", miss_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
